// File: rtl/alm_mac_acc.sv
// Purpose : signed saturating dot-product accumulator behind the ALM multiplier.
// Latency : last beat accepted at edge T -> out_valid high after edge T+2.
// Backpr. : result held in HOLD until out_ready; no input beats accepted meanwhile.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     product beat handshake; in_p is 17-bit one's complement,
//                         in_last marks the final term of the vector
//   out_valid/out_ready   result handshake
//   out_acc               saturated accumulator (ACC_W bits, two's complement)
//   out_count             number of terms accumulated (saturating)
//   out_ovf               sticky: accumulator or counter saturated in this vector
module alm_mac_acc #(
   parameter int ACC_W = 24,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [16:0]      in_p,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [LEN_W-1:0] out_count,
   output logic             out_ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      FLUSH = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam int EXT_W = ACC_W + 1 - 17;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_t             state_q, state_d;
   logic [16:0]        term_q, term_d;
   logic               s1_vld_q, s1_vld_d;
   logic               s1_last_q, s1_last_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;

   logic               accept;
   logic               last_pending;
   logic [ACC_W:0]     sum;

   always_comb begin
      state_d   = state_q;
      term_d    = '0;
      s1_vld_d  = 1'b0;
      s1_last_d = 1'b0;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      sum       = '0;

      // The last term still sits in S1 for one cycle after it is accepted;
      // the input must already be closed then, so the vector ends cleanly.
      last_pending = s1_vld_q & s1_last_q;

      if ((state_q == IDLE || state_q == ACCUM) && !last_pending) begin
         in_ready = 1'b1;
      end
      accept = in_valid & in_ready;

      // S1: one's complement to two's complement. Adding the sign bit maps
      // 17'h1FFFF (-0) to 0; the 17-bit add wraps exactly for that case.
      if (accept) begin
         term_d    = in_p + {16'd0, in_p[16]};
         s1_vld_d  = 1'b1;
         s1_last_d = in_last;
      end

      // S2: accumulate at ACC_W+1 bits; a mismatch of the two top bits means
      // the true sum left the ACC_W range, and the top bit gives its sign.
      if (s1_vld_q) begin
         sum = {acc_q[ACC_W-1], acc_q} + {{EXT_W{term_q[16]}}, term_q};
         if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
            ovf_d = 1'b1;
         end else begin
            acc_d = sum[ACC_W-1:0];
         end
         // A term that arrives with the counter already at all-ones cannot be
         // counted, which is what marks the counter as saturated.
         if (&cnt_q) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + LEN_W'(1);
         end
      end

      // The FSM enters FLUSH on the edge where S2 absorbs the last term, so
      // the result is complete and settled by the time HOLD presents it.
      unique case (state_q)
         IDLE: begin
            if (last_pending) begin
               state_d = FLUSH;
            end else if (accept && !in_last) begin
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (last_pending) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            state_d = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         term_q    <= '0;
         s1_vld_q  <= 1'b0;
         s1_last_q <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         term_q    <= term_d;
         s1_vld_q  <= s1_vld_d;
         s1_last_q <= s1_last_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
      end
   end

   assign out_acc   = acc_q;
   assign out_count = cnt_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_alm_mac_acc.sv
// Directed testbench for alm_mac_acc. Two instances share all inputs: the
// default ACC_W=24 build and an ACC_W=18 build used to reach saturation.
module tb_alm_mac_acc;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [16:0] in_p;
   logic        in_last;
   logic        out_ready;

   logic        in_ready;
   logic        out_valid;
   logic [23:0] out_acc;
   logic [7:0]  out_count;
   logic        out_ovf;

   logic        in_ready18;
   logic        out_valid18;
   logic [17:0] out_acc18;
   logic [7:0]  out_count18;
   logic        out_ovf18;

   int tests_run;
   int tests_failed;

   alm_mac_acc #(.ACC_W(24), .LEN_W(8)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_p      (in_p),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   alm_mac_acc #(.ACC_W(18), .LEN_W(8)) u_dut18 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready18),
      .in_p      (in_p),
      .in_last   (in_last),
      .out_valid (out_valid18),
      .out_ready (out_ready),
      .out_acc   (out_acc18),
      .out_count (out_count18),
      .out_ovf   (out_ovf18)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [16:0] p, input logic last);
      in_valid = 1'b1;
      in_p     = p;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_p     = '0;
   endtask

   task automatic wait_out(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL %s_timeout: out_valid=%0b after 20 cycles, required 1", name, out_valid);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_p      = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
      end
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid);
      end
      tests_run++;
      if (out_acc !== 24'd0 || out_count !== 8'd0 || out_ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs: acc=%0d count=%0d ovf=%0b, required 0/0/0", out_acc, out_count, out_ovf);
      end
   endtask

   task automatic test_single_beat();
      out_ready = 1'b1;
      send_beat(17'h00064, 1'b1);          // edge T
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_t0: out_valid=%0b in_ready=%0b, required 0/0", out_valid, in_ready);
      end
      tick();                               // edge T+1
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++; $display("FAIL single_t1_valid: got %0b, required 0", out_valid);
      end
      tick();                               // edge T+2
      tests_run++;
      if (out_valid !== 1'b1) begin
         tests_failed++; $display("FAIL single_t2_valid: got %0b, required 1", out_valid);
      end
      tests_run++;
      if (out_acc !== 24'd100 || out_count !== 8'd1 || out_ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_result: acc=%0d count=%0d ovf=%0b, required 100/1/0", out_acc, out_count, out_ovf);
      end
      tick();                               // handshake edge T+3
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_turnaround: in_ready=%0b out_valid=%0b, required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      send_beat(17'h00064, 1'b0);
      send_beat(17'h1FF9B, 1'b0);          // -100
      send_beat(17'h00032, 1'b1);
      wait_out("b2b");
      tests_run++;
      if (out_acc !== 24'd50 || out_count !== 8'd3 || out_ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_result: acc=%0d count=%0d ovf=%0b, required 50/3/0", out_acc, out_count, out_ovf);
      end
      tick();
   endtask

   task automatic test_zero_encodings();
      out_ready = 1'b1;
      send_beat(17'h1FFFF, 1'b0);          // -0
      send_beat(17'h00000, 1'b0);
      send_beat(17'h00005, 1'b1);
      wait_out("zero");
      tests_run++;
      if (out_acc !== 24'd5 || out_count !== 8'd3) begin
         tests_failed++;
         $display("FAIL zero_result: acc=%0d count=%0d, required 5/3", out_acc, out_count);
      end
      tick();
   endtask

   task automatic test_saturation();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send_beat(17'h0FFFF, (i == 3) ? 1'b1 : 1'b0);
      end
      wait_out("sat");
      tests_run++;
      if (out_acc18 !== 18'd131071 || out_ovf18 !== 1'b1 || out_count18 !== 8'd4) begin
         tests_failed++;
         $display("FAIL sat18_result: acc=%0d ovf=%0b count=%0d, required 131071/1/4", out_acc18, out_ovf18, out_count18);
      end
      tests_run++;
      if (out_acc !== 24'd262140 || out_ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL sat24_result: acc=%0d ovf=%0b, required 262140/0", out_acc, out_ovf);
      end
      tick();
      send_beat(17'h00001, 1'b1);
      wait_out("sat_next");
      tests_run++;
      if (out_acc18 !== 18'd1 || out_ovf18 !== 1'b0 || out_count18 !== 8'd1) begin
         tests_failed++;
         $display("FAIL sat18_cleared: acc=%0d ovf=%0b count=%0d, required 1/0/1", out_acc18, out_ovf18, out_count18);
      end
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send_beat(17'h00003, 1'b1);
      wait_out("bp");
      in_valid = 1'b1;
      in_p     = 17'h00009;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_acc !== 24'd3 ||
             out_count !== 8'd1 || out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_hold_%0d: in_ready=%0b out_valid=%0b acc=%0d count=%0d ovf=%0b, required 0/1/3/1/0",
                     i, in_ready, out_valid, out_acc, out_count, out_ovf);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();                               // output handshake
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_acc !== 24'd0) begin
         tests_failed++;
         $display("FAIL bp_release: in_ready=%0b out_valid=%0b acc=%0d, required 1/0/0", in_ready, out_valid, out_acc);
      end
      tick();                               // waiting beat accepted
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_p     = '0;
      wait_out("bp_next");
      tests_run++;
      if (out_acc !== 24'd9 || out_count !== 8'd1) begin
         tests_failed++;
         $display("FAIL bp_next_result: acc=%0d count=%0d, required 9/1", out_acc, out_count);
      end
      tick();
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b1;
      send_beat(17'h0000A, 1'b0);
      send_beat(17'h00014, 1'b0);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_p     = 17'h0001E;
      tick();
      rst_n    = 1'b1;
      in_valid = 1'b0;
      in_p     = '0;
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_acc !== 24'd0 ||
          out_count !== 8'd0 || out_ovf !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrst_state: in_ready=%0b out_valid=%0b acc=%0d count=%0d ovf=%0b, required 1/0/0/0/0",
                  in_ready, out_valid, out_acc, out_count, out_ovf);
      end
      send_beat(17'h00007, 1'b1);
      wait_out("midrst");
      tests_run++;
      if (out_acc !== 24'd7 || out_count !== 8'd1) begin
         tests_failed++;
         $display("FAIL midrst_result: acc=%0d count=%0d, required 7/1", out_acc, out_count);
      end
      tick();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_zero_encodings();
      test_saturation();
      test_backpressure();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
